// File: rtl/dht11_sensor_responder.sv
// rtl/dht11_sensor_responder.sv - DHT11 sensor-side emulator for the single-wire link
// Open-drain style: only ever pulls the line low; pull-up/tristate live above this block.
module dht11_sensor_responder #(
    parameter int START_MIN = 18000,
    parameter int T_WAIT    = 30,
    parameter int T_RESP    = 80,
    parameter int T_BIT_LOW = 50,
    parameter int T_ZERO_HI = 26,
    parameter int T_ONE_HI  = 70,
    parameter int CNT_W     = 19
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dht_in,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    output logic       dht_drive_low,
    output logic       busy,
    output logic       frame_done,
    output logic       bad_start
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HOST_LOW  = 3'd1,
        S_RESP_WAIT = 3'd2,
        S_RESP_LOW  = 3'd3,
        S_RESP_HIGH = 3'd4,
        S_BIT_LOW   = 3'd5,
        S_BIT_HIGH  = 3'd6,
        S_END_LOW   = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] L_START   = CNT_W'(START_MIN);
    localparam logic [CNT_W-1:0] L_WAIT    = CNT_W'(T_WAIT);
    localparam logic [CNT_W-1:0] L_RESP    = CNT_W'(T_RESP);
    localparam logic [CNT_W-1:0] L_BIT_LOW = CNT_W'(T_BIT_LOW);
    localparam logic [CNT_W-1:0] L_ZERO_HI = CNT_W'(T_ZERO_HI);
    localparam logic [CNT_W-1:0] L_ONE_HI  = CNT_W'(T_ONE_HI);

    logic             r_sync1;
    logic             r_line;
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [5:0]       r_bit_idx;
    logic [39:0]      r_frame;
    logic [7:0]       w_chk;
    logic [CNT_W-1:0] w_hi_len;
    logic             w_drive_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_bad_nxt;

    assign w_chk    = hum_int + hum_dec + temp_int + temp_dec;
    assign w_hi_len = r_frame[r_bit_idx] ? L_ONE_HI : L_ZERO_HI;

    // Synchronizer resets to "released" so reset does not look like a host start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_line  <= 1'b1;
        end else begin
            r_sync1 <= dht_in;
            r_line  <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            dht_drive_low <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            bad_start     <= 1'b0;
        end else begin
            r_state       <= w_next;
            dht_drive_low <= w_drive_nxt;
            busy          <= w_busy_nxt;
            frame_done    <= w_done_nxt;
            bad_start     <= w_bad_nxt;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!r_line) w_next = S_HOST_LOW;
            end
            S_HOST_LOW: begin
                if (r_line) w_next = (r_cnt >= L_START) ? S_RESP_WAIT : S_IDLE;
            end
            S_RESP_WAIT: begin
                if (r_cnt == L_WAIT) w_next = S_RESP_LOW;
            end
            S_RESP_LOW: begin
                if (r_cnt == L_RESP) w_next = S_RESP_HIGH;
            end
            S_RESP_HIGH: begin
                if (r_cnt == L_RESP) w_next = S_BIT_LOW;
            end
            S_BIT_LOW: begin
                if (r_cnt == L_BIT_LOW) w_next = S_BIT_HIGH;
            end
            S_BIT_HIGH: begin
                if (r_cnt == w_hi_len) w_next = (r_bit_idx == 6'd0) ? S_END_LOW : S_BIT_LOW;
            end
            S_END_LOW: begin
                if (r_cnt == L_BIT_LOW) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register together with it.
    always_comb begin
        w_drive_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_bad_nxt   = 1'b0;
        case (w_next)
            S_RESP_LOW, S_BIT_LOW, S_END_LOW: w_drive_nxt = 1'b1;
            default:                          w_drive_nxt = 1'b0;
        endcase
        case (w_next)
            S_IDLE, S_HOST_LOW: w_busy_nxt = 1'b0;
            default:            w_busy_nxt = 1'b1;
        endcase
        w_done_nxt = (r_state == S_END_LOW)  && (w_next == S_IDLE);
        w_bad_nxt  = (r_state == S_HOST_LOW) && (w_next == S_IDLE);
    end

    // Every phase counts 1..N while in the state; HOST_LOW saturates at START_MIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= (w_next == S_IDLE) ? '0 : {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (r_state == S_HOST_LOW) begin
            if (r_cnt < L_START) r_cnt <= r_cnt + 1'b1;
        end else if (r_state != S_IDLE) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame   <= '0;
            r_bit_idx <= '0;
        end else begin
            if (r_state == S_HOST_LOW && w_next == S_RESP_WAIT)
                r_frame <= {hum_int, hum_dec, temp_int, temp_dec, w_chk};
            if (r_state == S_RESP_HIGH && w_next == S_BIT_LOW)
                r_bit_idx <= 6'd39;
            else if (r_state == S_BIT_HIGH && w_next == S_BIT_LOW)
                r_bit_idx <= r_bit_idx - 6'd1;
        end
    end

endmodule

// File: tb/tb_dht11_sensor_responder.sv
// tb/tb_dht11_sensor_responder.sv - self-checking bench for dht11_sensor_responder
module tb_dht11_sensor_responder;

    localparam int START_MIN = 2000;
    localparam int T_WAIT    = 30;
    localparam int T_RESP    = 80;
    localparam int T_BIT_LOW = 50;
    localparam int T_ZERO_HI = 26;
    localparam int T_ONE_HI  = 70;
    localparam int BOUND     = 300;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dht_in = 1'b1;
    logic [7:0] hum_int = 8'h00;
    logic [7:0] hum_dec = 8'h00;
    logic [7:0] temp_int = 8'h00;
    logic [7:0] temp_dec = 8'h00;
    logic       dht_drive_low;
    logic       busy;
    logic       frame_done;
    logic       bad_start;

    int compared   = 0;
    int mismatched = 0;
    int busy_gaps  = 0;

    dht11_sensor_responder #(
        .START_MIN(START_MIN), .T_WAIT(T_WAIT), .T_RESP(T_RESP), .T_BIT_LOW(T_BIT_LOW),
        .T_ZERO_HI(T_ZERO_HI), .T_ONE_HI(T_ONE_HI), .CNT_W(19)
    ) dut (
        .clk(clk), .rst_n(rst_n), .dht_in(dht_in),
        .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec),
        .dht_drive_low(dht_drive_low), .busy(busy), .frame_done(frame_done), .bad_start(bad_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          host_low;
        logic [7:0]  b0, b1, b2, b3;
        bit          tamper;
        bit          accept;
        logic [39:0] frame;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic host_start(input int n);
        dht_in = 1'b0;
        repeat (n) @(negedge clk);
        dht_in = 1'b1;
    endtask

    // Width of the current level of dht_drive_low in cycles; optionally disturbs inputs mid-phase.
    task automatic measure(input logic level, input bit tamper, output int n);
        n = 0;
        while (dht_drive_low === level && n < BOUND) begin
            if (busy !== 1'b1) busy_gaps++;
            if (tamper && n == 10) begin
                hum_int = 8'h99;
                dht_in  = 1'b0;
            end
            if (tamper && n == 15) dht_in = 1'b1;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_frame(input logic [39:0] exp, input bit tamper, input int abort_bit);
        int k;
        int n;
        logic [39:0] got;
        got = '0;
        busy_gaps = 0;
        k = 0;
        while (dht_drive_low !== 1'b1 && k < BOUND) begin
            @(negedge clk);
            k++;
        end
        // Release is sampled on the first edge, then 2 sync stages plus T_WAIT.
        check("resp_latency", k, 3 + T_WAIT);
        measure(1'b1, 1'b0, n);
        check("resp_low", n, T_RESP);
        measure(1'b0, tamper, n);
        check("resp_high", n, T_RESP);
        for (int i = 39; i >= 0; i--) begin
            if (i == abort_bit) begin
                repeat (10) @(negedge clk);
                return;
            end
            measure(1'b1, 1'b0, n);
            check("bit_low", n, T_BIT_LOW);
            measure(1'b0, 1'b0, n);
            got[i] = (n > (T_ZERO_HI + T_ONE_HI) / 2);
            check("bit_high", n, exp[i] ? T_ONE_HI : T_ZERO_HI);
        end
        check("frame", got, exp);
        measure(1'b1, 1'b0, n);
        check("end_low", n, T_BIT_LOW);
        check("frame_done_pulse", frame_done, 1'b1);
        check("busy_end", busy, 1'b0);
        check("busy_gaps", busy_gaps, 0);
        @(negedge clk);
        check("frame_done_width", frame_done, 1'b0);
    endtask

    task automatic run_bad_start();
        int bad_cnt;
        int drv_cnt;
        int busy_cnt;
        bad_cnt = 0;
        drv_cnt = 0;
        busy_cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (bad_start === 1'b1) bad_cnt++;
            if (dht_drive_low !== 1'b0) drv_cnt++;
            if (busy !== 1'b0) busy_cnt++;
        end
        check("bad_start_pulses", bad_cnt, 1);
        check("bad_start_drive", drv_cnt, 0);
        check("bad_start_busy", busy_cnt, 0);
    endtask

    initial begin
        vecs[0] = '{host_low: START_MIN - 1, b0: 8'h11, b1: 8'h22, b2: 8'h33, b3: 8'h44,
                    tamper: 1'b0, accept: 1'b0, frame: 40'h0};
        vecs[1] = '{host_low: START_MIN, b0: 8'h37, b1: 8'h00, b2: 8'h19, b3: 8'h00,
                    tamper: 1'b1, accept: 1'b1, frame: 40'h37_00_19_00_50};
        vecs[2] = '{host_low: START_MIN + 500, b0: 8'hFF, b1: 8'hFF, b2: 8'hFF, b3: 8'hFF,
                    tamper: 1'b0, accept: 1'b1, frame: 40'hFF_FF_FF_FF_FC};
        vecs[3] = '{host_low: START_MIN, b0: 8'h12, b1: 8'h34, b2: 8'h56, b3: 8'h78,
                    tamper: 1'b0, accept: 1'b1, frame: 40'h12_34_56_78_14};

        repeat (3) @(negedge clk);
        check("rst_drive", dht_drive_low, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_bad_start", bad_start, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            hum_int  = vecs[v].b0;
            hum_dec  = vecs[v].b1;
            temp_int = vecs[v].b2;
            temp_dec = vecs[v].b3;
            host_start(vecs[v].host_low);
            if (vecs[v].accept) run_frame(vecs[v].frame, vecs[v].tamper, -1);
            else                run_bad_start();
            repeat (20) @(negedge clk);
        end

        hum_int = 8'hA5; hum_dec = 8'h5A; temp_int = 8'hC3; temp_dec = 8'h3C;
        host_start(START_MIN);
        run_frame(40'hA5_5A_C3_3C_FE, 1'b0, 20);
        check("pre_reset_drive", dht_drive_low, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_drive", dht_drive_low, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        hum_int = 8'h01; hum_dec = 8'h02; temp_int = 8'h03; temp_dec = 8'h04;
        host_start(START_MIN);
        run_frame(40'h01_02_03_04_0A, 1'b0, -1);
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", compared);
        $fatal(1, "watchdog");
    end

endmodule
